spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Rate encoder: converts a vector of per-channel spike counts into evenly spaced spike trains over a programmable window of timesteps.
- Inverse of the spike-accumulating activation path; it feeds the next layer's spike inputs.
- Loads one count vector per window via a valid/ready handshake.
- Emits one spike bit per channel per timestep, advanced by an external step strobe.

Parameters:
- NUM_CHANNELS, 3, number of independent encoder channels.
- TIMER_WIDTH, 5, width of the window length, the timestep counter and each spike count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- accumulate_interval  input  TIMER_WIDTH  window length N in timesteps; sampled only on input transfer.
- in_valid  input  1  count vector valid.
- in_ready  output  1  encoder can accept a count vector.
- spike_counts  input  NUM_CHANNELS*TIMER_WIDTH  packed counts; channel k occupies bits [k*TIMER_WIDTH +: TIMER_WIDTH].
- step_en  input  1  timestep advance strobe.
- spikes  output  NUM_CHANNELS  registered spike bits, bit k belongs to channel k.
- spike_valid  output  1  one-cycle pulse qualifying spikes.
- window_done  output  1  one-cycle pulse marking the final timestep of the window.
- busy  output  1  window in progress.

Behaviour:
- Reset values: in_ready=1, spikes=0, spike_valid=0, window_done=0, busy=0, FSM=IDLE; timer and all accumulators=0.
- FSM states: IDLE, ENCODE.
- IDLE: in_ready=1.
  - A transfer occurs when in_valid && in_ready.
  - On transfer: latch N=accumulate_interval; latch each count clamped to min(count_k, N); clear the timer and all accumulators.
  - If N!=0, go to ENCODE.
  - If N==0, stay in IDLE and pulse window_done (spike_valid=0, spikes=0) in the following cycle.
- ENCODE: in_ready=0, busy=1. in_valid is ignored and inputs are not sampled.
- Per step (step_en=1 in ENCODE), each channel updates its accumulator:
  - sum = acc + count, width TIMER_WIDTH+1, no overflow possible.
  - If sum >= N: spike_k=1 and acc <= sum - N.
  - Otherwise: spike_k=0 and acc <= sum.
- This produces exactly count_k spikes over N steps; the accumulator returns to 0 at window end.
- Latency: a step on cycle t makes spikes and spike_valid visible on cycle t+1. spike_valid is high for one cycle per step.
- When step_en=0: spikes are held at 0, spike_valid=0, and the timer and accumulators are held.
- Timer: increments on each step. On the step where timer==N-1:
  - window_done pulses in the same output cycle as that step's spike_valid.
  - FSM returns to IDLE and in_ready=1 on that output cycle.
  - A new transfer may occur on that same cycle.
- step_en in IDLE is ignored; no outputs are produced.
- rst mid-window aborts immediately; no window_done is emitted.
- Boundary counts:
  - count=0: no spikes.
  - count>=N: a spike on every step, clamped to N.
  - N=1: a single step, with window_done on that step.

Decomposition:
- Shared package (snn_pkg) holds:
  - FSM state enum {IDLE, ENCODE}.
  - Default TIMER_WIDTH.
  - Lane-slicing helper constant/function for the packed count bus.
- Sub-module spike_encoder_element, one instance per channel via generate:
  - Contains the count register, accumulator, compare/subtract and spike bit.
  - Controls: load, step, N.
- Top level holds the FSM, timer and handshake.

Test Plan:
- Reset: assert rst mid-window (N=8, 3 steps taken). Required: spikes=0, spike_valid=0, busy=0, in_ready=1 immediately. No window_done is emitted.
- Basic rate: N=4, counts {1,2,4}, step_en continuously high.
  - Ch0 spikes at step 4 only.
  - Ch1 spikes at steps 2 and 4.
  - Ch2 spikes at every step.
  - window_done coincides with step 4's spike_valid.
- Paced steps: N=5, counts {3,0,5}, step_en every 3rd cycle.
  - Exactly 5 spike_valid pulses, each one cycle after its strobe.
  - Totals per channel {3,0,5}.
  - in_valid asserted during the window is not accepted.
- Clamp and zero interval:
  - N=3, count 31 → 3 spikes.
  - N=0 transfer → window_done next cycle, no spike_valid, stays in IDLE.
- Back-to-back windows: a second in_valid held high through the end of window 1 (N=2) is accepted on window_done's cycle. The second window's N is sampled at that transfer, and its spikes start one step later.
- Random: 200 windows with random N in 1..31 and random counts. Per-channel spike totals equal min(count, N), and every accumulator returns to 0 at window end.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks: encoder FSM
// states, the default timer width and the packed count-bus lane slicing.
package snn_pkg;

    localparam int DEFAULT_TIMER_WIDTH = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } enc_state_t;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/spike_encoder_element.sv
// One rate-encoder lane: holds a clamped spike count and an error accumulator,
// firing whenever the accumulated count crosses the window length.
module spike_encoder_element
    import snn_pkg::*;
#(
    parameter int TIMER_WIDTH = DEFAULT_TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step,
    input  logic [TIMER_WIDTH-1:0] interval,
    input  logic [TIMER_WIDTH-1:0] count_in,
    output logic                   spike
);

    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] acc_q, acc_d;
    logic                   spike_q, spike_d;
    logic [TIMER_WIDTH:0]   sum;

    // The remainder after a spike is always below the interval, so the
    // truncated subtraction cannot lose information.
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        spike_d = 1'b0;
        sum     = {1'b0, acc_q} + {1'b0, count_q};
        if (load) begin
            count_d = (count_in > interval) ? interval : count_in;
            acc_d   = '0;
        end else if (step) begin
            if (sum >= {1'b0, interval}) begin
                spike_d = 1'b1;
                acc_d   = sum[TIMER_WIDTH-1:0] - interval;
            end else begin
                acc_d   = sum[TIMER_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: accepts one count vector per window and spreads each channel's
// count evenly as spikes across N externally-strobed timesteps.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int NUM_CHANNELS = 3,
    parameter int TIMER_WIDTH  = DEFAULT_TIMER_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [TIMER_WIDTH-1:0]              accumulate_interval,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CHANNELS*TIMER_WIDTH-1:0] spike_counts,
    input  logic                                step_en,
    output logic [NUM_CHANNELS-1:0]             spikes,
    output logic                                spike_valid,
    output logic                                window_done,
    output logic                                busy
);

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    enc_state_t             state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [TIMER_WIDTH-1:0] interval_q, interval_d;
    logic                   spike_valid_q, spike_valid_d;
    logic                   window_done_q, window_done_d;
    logic                   transfer;
    logic                   step;
    logic [TIMER_WIDTH-1:0] lane_interval;

    // Lanes clamp against the incoming interval during a transfer, and
    // against the latched one while encoding.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        interval_d    = interval_q;
        spike_valid_d = 1'b0;
        window_done_d = 1'b0;
        transfer      = in_valid && (state_q == IDLE);
        step          = step_en && (state_q == ENCODE);
        lane_interval = transfer ? accumulate_interval : interval_q;
        if (transfer) begin
            interval_d = accumulate_interval;
            timer_d    = '0;
            if (accumulate_interval != '0) begin
                state_d = ENCODE;
            end else begin
                window_done_d = 1'b1;
            end
        end else if (step) begin
            spike_valid_d = 1'b1;
            timer_d       = timer_q + ONE;
            if (timer_q == interval_q - ONE) begin
                window_done_d = 1'b1;
                timer_d       = '0;
                state_d       = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            interval_q    <= '0;
            spike_valid_q <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            interval_q    <= interval_d;
            spike_valid_q <= spike_valid_d;
            window_done_q <= window_done_d;
        end
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
        spike_encoder_element #(
            .TIMER_WIDTH (TIMER_WIDTH)
        ) u_elem (
            .clk      (clk),
            .rst      (rst),
            .load     (transfer),
            .step     (step),
            .interval (lane_interval),
            .count_in (spike_counts[lane_lsb(k, TIMER_WIDTH) +: TIMER_WIDTH]),
            .spike    (spikes[k])
        );
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == ENCODE);
    assign spike_valid = spike_valid_q;
    assign window_done = window_done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: a reference model predicts each
// output pulse into a queue that the negedge monitor drains and compares.
module tb_spike_rate_encoder;

    localparam int NC = 3;
    localparam int TW = 5;

    typedef struct {
        logic [NC-1:0]    spikes;
        logic             valid;
        logic             done;
        logic [NC*TW-1:0] totals;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [TW-1:0]    accumulate_interval;
    logic             in_valid;
    logic             in_ready;
    logic [NC*TW-1:0] spike_counts;
    logic             step_en;
    logic [NC-1:0]    spikes;
    logic             spike_valid;
    logic             window_done;
    logic             busy;

    int   total;
    int   bad;
    exp_t exp_q[$];
    bit   m_busy;
    int   m_n;
    int   m_timer;
    int   m_cnt[NC];
    int   m_loads;
    int   obs_tot[NC];

    spike_rate_encoder #(
        .NUM_CHANNELS (NC),
        .TIMER_WIDTH  (TW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .accumulate_interval (accumulate_interval),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .spike_counts        (spike_counts),
        .step_en             (step_en),
        .spikes              (spikes),
        .spike_valid         (spike_valid),
        .window_done         (window_done),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: spike at step s iff floor(s*c/N) advances, which
    // spreads c spikes evenly and lands the last one on step N when c>0.
    always @(posedge clk or posedge rst) begin
        exp_t ne;
        if (rst) begin
            m_busy  = 1'b0;
            m_timer = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (in_valid) begin
                m_n     = int'(accumulate_interval);
                m_timer = 0;
                m_loads++;
                for (int k = 0; k < NC; k++) begin
                    m_cnt[k] = int'(spike_counts[k*TW +: TW]);
                    if (m_cnt[k] > m_n) m_cnt[k] = m_n;
                end
                if (m_n == 0) begin
                    ne.spikes = '0;
                    ne.valid  = 1'b0;
                    ne.done   = 1'b1;
                    ne.totals = '0;
                    exp_q.push_back(ne);
                end else begin
                    m_busy = 1'b1;
                end
            end
        end else if (step_en) begin
            int s;
            s = m_timer + 1;
            ne.valid  = 1'b1;
            ne.done   = (s == m_n);
            ne.totals = '0;
            for (int k = 0; k < NC; k++) begin
                ne.spikes[k] = ((s * m_cnt[k]) / m_n) > (((s - 1) * m_cnt[k]) / m_n);
                ne.totals[k*TW +: TW] = TW'(m_cnt[k]);
            end
            exp_q.push_back(ne);
            m_timer = s;
            if (ne.done) m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t me;
        if (rst) begin
            for (int k = 0; k < NC; k++) obs_tot[k] = 0;
        end else begin
            checkOutput("in_ready", 32'(in_ready), 32'(!m_busy));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            if (spike_valid || window_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'({spike_valid, window_done}), 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    checkOutput("spike_valid", 32'(spike_valid), 32'(me.valid));
                    checkOutput("spikes", 32'(spikes), 32'(me.spikes));
                    checkOutput("window_done", 32'(window_done), 32'(me.done));
                    if (spike_valid) begin
                        for (int k = 0; k < NC; k++) obs_tot[k] += int'(spikes[k]);
                    end
                    if (me.done) begin
                        for (int k = 0; k < NC; k++) begin
                            checkOutput($sformatf("total_ch%0d", k), 32'(obs_tot[k]),
                                        32'(me.totals[k*TW +: TW]));
                            obs_tot[k] = 0;
                        end
                    end
                end
            end else begin
                checkOutput("quiet_spikes", 32'(spikes), 32'd0);
            end
        end
    end

    // Loads one window and strobes step_en every pace cycles until the
    // model reports the window closed; poke drives junk in_valid meanwhile.
    task automatic applyStimulus(input logic [TW-1:0] n, input logic [NC*TW-1:0] cnts,
                                 input int pace, input bit poke);
        int guard;
        int cyc;
        guard = 0;
        while (m_busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        accumulate_interval = n;
        spike_counts        = cnts;
        in_valid            = 1'b1;
        step_en             = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc      = 0;
        while (m_busy && guard < 2000) begin
            cyc++;
            step_en = ((cyc % pace) == 0);
            if (poke) begin
                in_valid            = 1'b1;
                accumulate_interval = TW'($urandom_range(0, 31));
                spike_counts        = (NC*TW)'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        step_en  = 1'b0;
        in_valid = 1'b0;
        if (guard >= 2000) checkOutput("window_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int start;
        int guard;
        total               = 0;
        bad                 = 0;
        m_loads             = 0;
        rst                 = 1'b1;
        in_valid            = 1'b0;
        step_en             = 1'b0;
        accumulate_interval = '0;
        spike_counts        = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_spikes", 32'(spikes), 32'd0);
        checkOutput("reset_valid", 32'(spike_valid), 32'd0);
        checkOutput("reset_done", 32'(window_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(5'd4, {5'd4, 5'd2, 5'd1}, 1, 1'b0);
        applyStimulus(5'd5, {5'd5, 5'd0, 5'd3}, 3, 1'b1);
        applyStimulus(5'd3, {5'd0, 5'd0, 5'd31}, 1, 1'b0);
        applyStimulus(5'd0, {5'd9, 5'd5, 5'd7}, 1, 1'b0);
        step_en = 1'b1;
        repeat (3) @(negedge clk);
        step_en = 1'b0;

        accumulate_interval = 5'd2;
        spike_counts        = {5'd1, 5'd2, 5'd1};
        in_valid            = 1'b1;
        step_en             = 1'b1;
        @(negedge clk);
        start               = m_loads;
        accumulate_interval = 5'd3;
        spike_counts        = {5'd3, 5'd2, 5'd1};
        guard = 0;
        while (m_loads == start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        while (m_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        step_en = 1'b0;
        checkOutput("b2b_second_load", 32'(m_loads - start), 32'd1);

        accumulate_interval = 5'd8;
        spike_counts        = {5'd8, 5'd4, 5'd2};
        in_valid            = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        step_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step_en = 1'b0;
        #1;
        checkOutput("abort_spikes", 32'(spikes), 32'd0);
        checkOutput("abort_valid", 32'(spike_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        step_en = 1'b1;
        repeat (4) @(negedge clk);
        step_en = 1'b0;

        for (int w = 0; w < 200; w++) begin
            logic [NC*TW-1:0] cnts;
            for (int k = 0; k < NC; k++) cnts[k*TW +: TW] = TW'($urandom_range(0, 31));
            applyStimulus(TW'($urandom_range(1, 31)), cnts, int'($urandom_range(1, 3)),
                          1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
